// File: rtl/raisin64_pkg.sv
// Shared raisin64 definitions used by the instruction fetch path.
//   WORD_W           : machine word / instruction fetch width in bits
//   INSN_BYTES       : bytes per fetched word (fetch address stride)
//   DEFAULT_RESET_PC : first fetch address after reset
//   fetch_entry_t    : prefetch buffer entry, {pc, data}
//   align_pc()       : clears the byte-offset bits of an address
package raisin64_pkg;

    localparam int WORD_W     = 64;
    localparam int INSN_BYTES = 8;
    localparam int OFS_W      = $clog2(INSN_BYTES);

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:OFS_W], {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch_entry_t for the instruction prefetcher.
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared too,
//                so the read port shows zeros while empty after reset)
//   flush      : drops all entries; push/pop in the same cycle are ignored
//   push, wdata: write an entry at the write pointer
//   pop        : advance the read pointer
//   rdata      : entry at the read pointer (valid when count != 0)
//   count      : occupancy, 0..DEPTH
module prefetch_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The issue logic upstream must never let a word land in a full buffer.
    always @(posedge clk) begin
        if (rst_n && !flush)
            assert (!(push && count == CNT_W'(DEPTH)))
                else $error("prefetch_fifo overflow");
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch buffer between the instruction RAM and fetch stage.
// Issues sequential 64-bit reads to a 1-cycle-latency RAM, buffers returned
// words with their addresses, and hands them out over valid/ready.
//   clk, rst_n            : clock, asynchronous active-low reset
//   redirect, redirect_pc : flush and restart fetch at redirect_pc (aligned)
//   out_valid/out_ready   : handshake to the pipeline
//   out_data, out_pc      : instruction word and its byte address
//   mem_cs, mem_addr      : RAM read request (combinational)
//   mem_data              : RAM read data, valid the cycle after mem_cs
module ifetch_prefetch
    import raisin64_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [WORD_W-1:0] out_pc,
    output logic              mem_cs,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [WORD_W-1:0] fetch_pc;
    logic              inflight;
    logic [WORD_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic              push;
    fetch_entry_t      wentry;
    fetch_entry_t      rentry;

    // A redirect cycle never pops: the buffer is being thrown away.
    assign pop  = out_valid & out_ready & ~redirect;
    assign push = inflight & ~redirect;

    // Buffer slots already spoken for after this cycle: held words plus the
    // word returning now, minus the one leaving. pop implies count >= 1.
    assign occ = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);

    always_comb begin
        mem_cs   = 1'b0;
        mem_addr = fetch_pc;
        if (redirect) begin
            mem_cs   = 1'b1;
            mem_addr = align_pc(redirect_pc);
        end else begin
            mem_cs = occ < OCC_W'(DEPTH);
        end
        // No requests may leave the block while reset is held.
        if (!rst_n) mem_cs = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (mem_cs) fetch_pc <= mem_addr + WORD_W'(INSN_BYTES);
            inflight    <= mem_cs;
            inflight_pc <= mem_addr;
        end
    end

    assign wentry.pc   = inflight_pc;
    assign wentry.data = mem_data;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .count (count)
    );

    assign out_valid = count != '0;
    assign out_data  = rentry.data;
    assign out_pc    = rentry.pc;

endmodule

// File: tb/tb_ifetch_prefetch.sv
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [63:0] out_pc;
    logic        mem_cs;
    logic [63:0] mem_addr;
    logic [63:0] mem_data = '0;

    int pass_cnt = 0;
    int total    = 0;

    ifetch_prefetch #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pc      (out_pc),
        .mem_cs      (mem_cs),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_1234, a[63:32] ^ ~a[31:0]};
    endfunction

    // Single-cycle-latency instruction RAM.
    always @(posedge clk) if (mem_cs) mem_data <= ram_word(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic        rst_n;
        logic        redirect;
        logic [63:0] rpc;
        logic        ready;
        logic        e_cs;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic [63:0] rpc,
                                input logic rdy, input logic cs, input logic [63:0] addr,
                                input logic v, input logic [63:0] pc);
        vec_t t;
        t = '{r, rd, rpc, rdy, cs, addr, v, pc};
        return t;
    endfunction

    initial begin
        logic [63:0] exp_next;
        logic [63:0] tgt;
        int age;
        int gap;
        int pops;

        // reset held
        vq.push_back(mk(0,0,0,0, 0,0, 0,0));
        vq.push_back(mk(0,0,0,0, 0,0, 0,0));
        // out_ready low from reset: four issues then stall
        vq.push_back(mk(1,0,0,0, 1,64'd0,  0,0));
        vq.push_back(mk(1,0,0,0, 1,64'd8,  0,0));
        vq.push_back(mk(1,0,0,0, 1,64'd16, 1,64'd0));
        vq.push_back(mk(1,0,0,0, 1,64'd24, 1,64'd0));
        vq.push_back(mk(1,0,0,0, 0,64'd32, 1,64'd0));
        vq.push_back(mk(1,0,0,0, 0,64'd32, 1,64'd0));
        // drain in order, fetch resumes at 32
        vq.push_back(mk(1,0,0,1, 1,64'd32, 1,64'd0));
        vq.push_back(mk(1,0,0,1, 1,64'd40, 1,64'd8));
        vq.push_back(mk(1,0,0,1, 1,64'd48, 1,64'd16));
        vq.push_back(mk(1,0,0,1, 1,64'd56, 1,64'd24));
        vq.push_back(mk(1,0,0,1, 1,64'd64, 1,64'd32));
        // redirect to 0x40 with 3 words buffered and one in flight
        vq.push_back(mk(1,1,64'h40,0, 1,64'h40, 1,64'd40));
        vq.push_back(mk(1,0,0,1,      1,64'h48, 0,0));
        vq.push_back(mk(1,0,0,1,      1,64'h50, 1,64'h40));
        // redirect to 0x47 with out_ready high
        vq.push_back(mk(1,1,64'h47,1, 1,64'h40, 1,64'h48));
        vq.push_back(mk(1,0,0,1,      1,64'h48, 0,0));
        vq.push_back(mk(1,0,0,1,      1,64'h50, 1,64'h40));
        vq.push_back(mk(1,0,0,1,      1,64'h58, 1,64'h48));
        // reset mid-stream, then restart with out_ready high
        vq.push_back(mk(0,0,0,1, 0,0, 0,0));
        vq.push_back(mk(1,0,0,1, 1,64'd0,  0,0));
        vq.push_back(mk(1,0,0,1, 1,64'd8,  0,0));
        vq.push_back(mk(1,0,0,1, 1,64'd16, 1,64'd0));
        vq.push_back(mk(1,0,0,1, 1,64'd24, 1,64'd8));
        vq.push_back(mk(1,0,0,1, 1,64'd32, 1,64'd16));
        vq.push_back(mk(1,0,0,1, 1,64'd40, 1,64'd24));

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            rst_n       = vq[i].rst_n;
            redirect    = vq[i].redirect;
            redirect_pc = vq[i].rpc;
            out_ready   = vq[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d mem_cs", i), {63'd0, mem_cs}, {63'd0, vq[i].e_cs});
            chk($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, vq[i].e_valid});
            if (vq[i].rst_n)
                chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vq[i].e_pc);
                chk($sformatf("v%0d out_data", i), out_data, ram_word(vq[i].e_pc));
            end
            if (!vq[i].rst_n) begin
                chk($sformatf("v%0d rst out_pc", i), out_pc, 64'd0);
                chk($sformatf("v%0d rst out_data", i), out_data, 64'd0);
            end
        end

        // Random out_ready with periodic redirects; output stream must be
        // sequential words starting at each redirect target.
        exp_next = '0;
        tgt      = '0;
        age      = 99;
        gap      = 0;
        pops     = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            redirect_pc = {$urandom, $urandom};
            if (gap == 0) begin
                redirect = 1'b1;
                gap = $urandom_range(5, 20);
            end else begin
                redirect = 1'b0;
                gap--;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (redirect) begin
                tgt = {redirect_pc[63:3], 3'b000};
                chk("rand redirect mem_cs", {63'd0, mem_cs}, 64'd1);
                chk("rand redirect mem_addr", mem_addr, tgt);
                age = 0;
            end else if (age < 99) begin
                age++;
            end
            if (age == 1) chk("rand N+1 out_valid", {63'd0, out_valid}, 64'd0);
            if (age == 2) begin
                chk("rand N+2 out_valid", {63'd0, out_valid}, 64'd1);
                chk("rand N+2 out_pc", out_pc, tgt);
            end
            if (out_valid && out_ready && !redirect) begin
                chk("rand pop out_pc", out_pc, exp_next);
                chk("rand pop out_data", out_data, ram_word(exp_next));
                exp_next = exp_next + 64'd8;
                pops++;
            end
            if (redirect) exp_next = tgt;
        end
        chk("rand enough pops", {63'd0, pops > 100}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
